// File: rtl/am_argmax_tracker.sv
// Argmax tracker for the associative-memory sweep: follows best and second-best
// similarity scores and reports the winning address, its score and the top-2 margin.
module am_argmax_tracker #(
  parameter int unsigned N             = 2048,
  parameter int unsigned AM_ADDR_WIDTH = 13,
  localparam int unsigned SCORE_W      = $clog2(N)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [AM_ADDR_WIDTH-1:0] last_addr_i,
  input  logic                     score_valid_i,
  input  logic [SCORE_W-1:0]       score_i,
  input  logic [AM_ADDR_WIDTH-1:0] score_addr_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     result_valid_o,
  output logic [AM_ADDR_WIDTH-1:0] best_addr_o,
  output logic [SCORE_W-1:0]       best_score_o,
  output logic [SCORE_W-1:0]       second_score_o,
  output logic [SCORE_W-1:0]       margin_o,
  output logic                     err_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [AM_ADDR_WIDTH-1:0] ADDR_ZERO = {AM_ADDR_WIDTH{1'b0}};
  localparam logic [AM_ADDR_WIDTH-1:0] ADDR_ONE  = AM_ADDR_WIDTH'(1);
  localparam logic [SCORE_W-1:0]       SCORE_ZERO = {SCORE_W{1'b0}};

  logic [1:0]               state_r,  state_nxt_s;
  logic [AM_ADDR_WIDTH-1:0] cnt_r,    cnt_nxt_s;
  logic [AM_ADDR_WIDTH-1:0] last_r,   last_nxt_s;
  logic                     first_r,  first_nxt_s;
  logic [AM_ADDR_WIDTH-1:0] baddr_r,  baddr_nxt_s;
  logic [SCORE_W-1:0]       best_r,   best_nxt_s;
  logic [SCORE_W-1:0]       second_r, second_nxt_s;
  logic [SCORE_W-1:0]       margin_r, margin_nxt_s;
  logic                     err_r,    err_nxt_s;
  logic                     rv_r,     rv_nxt_s;
  logic                     busy_r,   done_r;

  // Next-state, ranking and protocol-error logic
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    last_nxt_s   = last_r;
    first_nxt_s  = first_r;
    baddr_nxt_s  = baddr_r;
    best_nxt_s   = best_r;
    second_nxt_s = second_r;
    err_nxt_s    = err_r;
    rv_nxt_s     = rv_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_nxt_s  = ST_SEARCH;
          last_nxt_s   = last_addr_i;
          cnt_nxt_s    = ADDR_ZERO;
          first_nxt_s  = 1'b1;
          baddr_nxt_s  = ADDR_ZERO;
          best_nxt_s   = SCORE_ZERO;
          second_nxt_s = SCORE_ZERO;
          err_nxt_s    = 1'b0;
          rv_nxt_s     = 1'b0;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
        // A stray beat outside a search is dropped; in DONE it wins over a restart's clear
        err_nxt_s = err_nxt_s | (score_valid_i & ((state_r == ST_DONE) | ~start_i));
      end
      ST_SEARCH: begin
        err_nxt_s = err_r | start_i | (score_valid_i & (score_addr_i != cnt_r));
        if (score_valid_i) begin
          if (first_r) begin
            best_nxt_s  = score_i;
            baddr_nxt_s = score_addr_i;
            first_nxt_s = 1'b0;
          end else if (score_i > best_r) begin
            second_nxt_s = best_r;
            best_nxt_s   = score_i;
            baddr_nxt_s  = score_addr_i;
          end else if (score_i > second_r) begin
            second_nxt_s = score_i;
          end else begin
            second_nxt_s = second_r;
          end
          // Counter holds on the last beat so an all-ones last_addr never wraps
          if (cnt_r == last_r) begin
            state_nxt_s = ST_DONE;
            rv_nxt_s    = 1'b1;
          end else begin
            cnt_nxt_s   = cnt_r + ADDR_ONE;
          end
        end else begin
          state_nxt_s = ST_SEARCH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    margin_nxt_s = best_nxt_s - second_nxt_s;
  end

  // State and result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      cnt_r    <= ADDR_ZERO;
      last_r   <= ADDR_ZERO;
      first_r  <= 1'b0;
      baddr_r  <= ADDR_ZERO;
      best_r   <= SCORE_ZERO;
      second_r <= SCORE_ZERO;
      margin_r <= SCORE_ZERO;
      err_r    <= 1'b0;
      rv_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      last_r   <= last_nxt_s;
      first_r  <= first_nxt_s;
      baddr_r  <= baddr_nxt_s;
      best_r   <= best_nxt_s;
      second_r <= second_nxt_s;
      margin_r <= margin_nxt_s;
      err_r    <= err_nxt_s;
      rv_r     <= rv_nxt_s;
      busy_r   <= (state_nxt_s == ST_SEARCH);
      done_r   <= (state_nxt_s == ST_DONE);
    end
  end

  assign busy_o         = busy_r;
  assign done_o         = done_r;
  assign result_valid_o = rv_r;
  assign best_addr_o    = baddr_r;
  assign best_score_o   = best_r;
  assign second_score_o = second_r;
  assign margin_o       = margin_r;
  assign err_o          = err_r;

endmodule

// File: tb/tb_am_argmax_tracker.sv
// Scoreboard bench for am_argmax_tracker: expected results are queued when a
// search is issued and checked by a monitor whenever done_o pulses.
module tb_am_argmax_tracker;

  localparam int AW = 13;
  localparam int SW = 11;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] last_addr_i = '0;
  logic          score_valid_i = 1'b0;
  logic [SW-1:0] score_i = '0;
  logic [AW-1:0] score_addr_i = '0;
  logic          busy_o, done_o, result_valid_o, err_o;
  logic [AW-1:0] best_addr_o;
  logic [SW-1:0] best_score_o, second_score_o, margin_o;

  typedef struct {
    int addr;
    int best;
    int second;
    int margin;
    int err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  am_argmax_tracker #(.N(2048), .AM_ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .last_addr_i(last_addr_i),
    .score_valid_i(score_valid_i), .score_i(score_i), .score_addr_i(score_addr_i),
    .busy_o(busy_o), .done_o(done_o), .result_valid_o(result_valid_o),
    .best_addr_o(best_addr_o), .best_score_o(best_score_o),
    .second_score_o(second_score_o), .margin_o(margin_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void chk(string nm, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endfunction

  function automatic void push(int a, int b, int s, int e);
    exp_t x;
    x.addr = a; x.best = b; x.second = s; x.margin = b - s; x.err = e;
    exp_q.push_back(x);
  endfunction

  // Monitor: every done_o pulse must match the oldest queued expectation
  always @(negedge clk_i) begin
    if (rst_ni && done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending search");
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_best_addr", int'(best_addr_o), mon_e.addr);
        chk("res_best", int'(best_score_o), mon_e.best);
        chk("res_second", int'(second_score_o), mon_e.second);
        chk("res_margin", int'(margin_o), mon_e.margin);
        chk("res_err", int'(err_o), mon_e.err);
        chk("res_valid", int'(result_valid_o), 1);
        chk("res_busy", int'(busy_o), 0);
      end
    end
  end

  // One cycle of stimulus, applied on the falling edge
  task automatic cyc(input logic st, input logic [AW-1:0] la, input logic sv,
                     input int sc, input int ad);
    @(negedge clk_i);
    start_i = st; last_addr_i = la; score_valid_i = sv;
    score_i = SW'(sc); score_addr_i = AW'(ad);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 0, 0);
  endtask

  task automatic beat(input int sc, input int ad);
    cyc(1'b0, '0, 1'b1, sc, ad);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_rv"}, int'(result_valid_o), 0);
    chk({tag, "_addr"}, int'(best_addr_o), 0);
    chk({tag, "_best"}, int'(best_score_o), 0);
    chk({tag, "_second"}, int'(second_score_o), 0);
    chk({tag, "_margin"}, int'(margin_o), 0);
    chk({tag, "_err"}, int'(err_o), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      start_i = 1'($urandom); score_valid_i = 1'($urandom);
      last_addr_i = AW'($urandom); score_i = SW'($urandom); score_addr_i = AW'($urandom);
    end
    #1 check_zero("reset");
    idle();
    rst_ni = 1'b1;
    beat(5, 0);
    idle();
    chk("stray_beat_err", int'(err_o), 1);
    chk("stray_beat_rv", int'(result_valid_o), 0);

    // Basic search
    push(1, 250, 180, 0);
    cyc(1'b1, 13'd3, 1'b0, 0, 0);
    beat(100, 0);
    chk("basic_busy", int'(busy_o), 1);
    chk("basic_err_cleared", int'(err_o), 0);
    beat(250, 1); beat(180, 2); beat(90, 3);
    idle();
    chk("basic_done_latency", int'(done_o), 1);
    idle();
    chk("basic_done_pulse", int'(done_o), 0);
    chk("basic_rv_hold", int'(result_valid_o), 1);

    // Ties and bubbles
    push(0, 200, 200, 0);
    cyc(1'b1, 13'd2, 1'b0, 0, 0);
    beat(200, 0); idle(); idle();
    chk("tie_busy_bubble", int'(busy_o), 1);
    beat(200, 1); beat(150, 2);
    idle();
    chk("tie_done", int'(done_o), 1);

    // Single entry, full-scale score
    push(0, 2047, 0, 0);
    cyc(1'b1, 13'd0, 1'b0, 0, 0);
    beat(2047, 0);
    idle();
    chk("single_done", int'(done_o), 1);

    // Protocol errors: start mid-search and an out-of-order address
    push(2, 30, 20, 1);
    cyc(1'b1, 13'd2, 1'b0, 0, 0);
    beat(10, 0);
    cyc(1'b1, 13'd0, 1'b0, 0, 0);
    idle();
    chk("midstart_err", int'(err_o), 1);
    chk("midstart_busy", int'(busy_o), 1);
    beat(30, 2); beat(20, 2);
    idle();
    chk("proto_done", int'(done_o), 1);

    // Reset mid-search: no done, everything cleared
    cyc(1'b1, 13'd3, 1'b0, 0, 0);
    chk("abort_err_cleared", int'(err_o), 1);
    beat(5, 0);
    chk("abort_err_clear", int'(err_o), 0);
    beat(6, 1);
    @(negedge clk_i);
    score_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1 check_zero("abort");
    idle(); idle();
    rst_ni = 1'b1;
    idle(); idle(); idle();
    chk("abort_no_done", int'(done_o), 0);

    // New search, restarted straight from its DONE cycle
    push(1, 60, 40, 0);
    cyc(1'b1, 13'd1, 1'b0, 0, 0);
    beat(40, 0); beat(60, 1);
    push(0, 7, 0, 0);
    cyc(1'b1, 13'd0, 1'b0, 0, 0);
    chk("restart_done", int'(done_o), 1);
    beat(7, 0);
    chk("restart_rv", int'(result_valid_o), 0);
    chk("restart_busy", int'(busy_o), 1);
    idle();
    chk("restart2_done", int'(done_o), 1);
    idle(); idle();
    chk("pending_results", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/am_argmax_tracker.md
Name: am_argmax_tracker

Overview:
- Consumer of the bit counter output stream. Receives one (similarity score, AM address) beat per cycle while the associative memory (AM) is swept.
- Tracks the best and second-best scores, then reports the winning class address, its score and the top-2 margin.
- Sits between bit_counter and the classification result register / host-visible status.

Parameters:
N, 2048, hypervector dimension; score width SCORE_W = $clog2(N)
AM_ADDR_WIDTH, 13, AM address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  single-cycle pulse that starts a search; accepted in IDLE or DONE
last_addr_i  in  AM_ADDR_WIDTH  number of AM entries minus 1; latched on accepted start_i
score_valid_i  in  1  score beat valid (bit_count_out_valid)
score_i  in  SCORE_W  similarity score
score_addr_i  in  AM_ADDR_WIDTH  AM address the score belongs to
busy_o  out  1  high while in SEARCH
done_o  out  1  one-cycle pulse, high during the DONE state
result_valid_o  out  1  results hold a completed search; level signal
best_addr_o  out  AM_ADDR_WIDTH  address of the highest score
best_score_o  out  SCORE_W  highest score
second_score_o  out  SCORE_W  second-highest score
margin_o  out  SCORE_W  best_score_o - second_score_o, registered
err_o  out  1  sticky protocol error; cleared on accepted start_i

Behaviour:
- Reset: every output 0; state IDLE; internal beat counter, latched last_addr and first-beat flag cleared. Reset mid-search aborts the search with no done_o.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - start_i latches last_addr_i, clears best/second/margin/err_o, sets result_valid_o=0 and the first flag, clears the counter, then moves to SEARCH.
  - score_valid_i without start_i sets err_o; the beat is discarded.
- SEARCH (busy_o=1): each cycle with score_valid_i=1 is one beat. Cycles without it are bubbles and are allowed.
  - First beat of the search: best_score<=score_i, best_addr<=score_addr_i, second stays 0, first flag cleared.
  - Later beats:
    - If score_i > best: second<=best, best<=score_i, best_addr<=score_addr_i.
    - Else if score_i > second: second<=score_i.
    - Comparisons are strict unsigned, so on a tie the earliest-received address wins and a tying score becomes the second score.
  - margin_o is recomputed from the updated best/second on the same edge.
  - score_addr_i != counter: set err_o, but the beat is still processed with the supplied address.
  - Counter increments per beat. The beat with counter == latched last_addr is the last one: on that edge state<=DONE and result_valid_o<=1.
  - start_i in SEARCH sets err_o and is otherwise ignored.
- DONE: lasts one cycle.
  - done_o=1 and results are stable; busy_o=0.
  - Next state is IDLE, or SEARCH if start_i=1 in this cycle (same actions as the IDLE start).
  - score_valid_i in DONE sets err_o; the beat is discarded.
- Latency: done_o is high the cycle immediately after the last beat is sampled. Results hold until the next accepted start_i or reset.
- last_addr_i=0: a single beat completes the search; second_score_o=0 and margin_o=best.
- Widths: all score arithmetic is SCORE_W unsigned. margin cannot underflow because best >= second by construction. The counter is AM_ADDR_WIDTH wide; last_addr = 2^AM_ADDR_WIDTH-1 is legal and the counter stops at that value without wrapping.
- Back-to-back beats every cycle must be supported, with no backpressure. The block has no ready signal; the upstream rate is fixed by the AM sweep.

Test Plan:
- Reset: hold rst_ni=0 with random inputs -> all outputs 0. Release, drive score_valid_i=1 -> err_o=1 and result_valid_o stays 0.
- Basic search: start last_addr=3; beats 100@0, 250@1, 180@2, 90@3 every cycle -> done_o one cycle after beat 3; best_addr=1, best=250, second=180, margin=70, result_valid=1, err=0.
- Ties and bubbles: start last_addr=2; beats 200@0, two idle cycles, 200@1, 150@2 -> best_addr=0, best=200, second=200, margin=0, busy_o high until the DONE cycle.
- Single entry / full-scale value: start last_addr=0; beat 2047@0 -> done next cycle, best=2047, second=0, margin=2047.
- Protocol errors: search with addresses 0, 2, 2 (last=2) -> err_o=1 while results are still computed. start_i mid-search -> ignored, err=1. Next accepted start clears err.
- Reset mid-search and restart from DONE: drop rst_ni after 2 of 4 beats -> all outputs 0, no done_o. New search completes normally; start_i in its DONE cycle -> straight to SEARCH with result_valid_o=0 next cycle.
